// File: rtl/mac_pkg.sv
// Shared constants for the systolic-array MAC datapath.
// Holds the instruction bit positions and the default operand widths.
package mac_pkg;
    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;
    localparam int BW        = 2;
    localparam int W_BW      = 4;
    localparam int PSUM_BW   = 8;
endpackage

// File: rtl/mac.sv
// Combinational signed multiply-accumulate: out = a*b + c, wrapped to psum_bw bits.
// a and b are two's complement and are sign-extended before the multiply.
module mac #(
    parameter int a_bw    = 2,
    parameter int w_bw    = 4,
    parameter int psum_bw = 8
) (
    input  logic [a_bw-1:0]    a,
    input  logic [w_bw-1:0]    b,
    input  logic [psum_bw-1:0] c,
    output logic [psum_bw-1:0] out
);
    logic signed [psum_bw-1:0] a_ext_s;
    logic signed [psum_bw-1:0] b_ext_s;
    logic signed [psum_bw-1:0] prod_s;

    assign a_ext_s = psum_bw'(signed'(a));
    assign b_ext_s = psum_bw'(signed'(b));
    // Low psum_bw bits of the product are the same whether or not the full product is kept.
    assign prod_s  = a_ext_s * b_ext_s;
    assign out     = prod_s + c;
endmodule

// File: rtl/mac_tile.sv
// Weight-stationary systolic processing element: registers west data and instruction,
// keeps one weight per reset, and presents a*weight + psum to the south.
module mac_tile
    import mac_pkg::*;
#(
    parameter int bw      = BW,
    parameter int w_bw    = W_BW,
    parameter int psum_bw = PSUM_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [w_bw-1:0]    in_w,
    input  logic [1:0]         inst_w,
    input  logic [psum_bw-1:0] in_n,
    output logic [w_bw-1:0]    out_e,
    output logic [1:0]         inst_e,
    output logic [psum_bw-1:0] out_s
);
    logic [w_bw-1:0]    a_r;
    logic [w_bw-1:0]    b_r;
    logic [psum_bw-1:0] c_r;
    logic [1:0]         inst_r;
    logic               load_ready_r;

    logic [w_bw-1:0]    a_nxt_s;
    logic [w_bw-1:0]    b_nxt_s;
    logic [psum_bw-1:0] c_nxt_s;
    logic [1:0]         inst_nxt_s;
    logic               load_ready_nxt_s;

    // Next-state: capture data, consume the first load locally, pass later loads east.
    always_comb begin
        a_nxt_s          = a_r;
        b_nxt_s          = b_r;
        c_nxt_s          = c_r;
        inst_nxt_s       = 2'b00;
        load_ready_nxt_s = load_ready_r;

        if (inst_w != 2'b00) begin
            a_nxt_s = in_w;
        end else begin
            a_nxt_s = a_r;
        end

        if (inst_w[INST_LOAD]) begin
            if (load_ready_r) begin
                b_nxt_s               = in_w;
                load_ready_nxt_s      = 1'b0;
                inst_nxt_s[INST_LOAD] = 1'b0;
            end else begin
                b_nxt_s               = b_r;
                inst_nxt_s[INST_LOAD] = 1'b1;
            end
        end else begin
            inst_nxt_s[INST_LOAD] = 1'b0;
        end

        inst_nxt_s[INST_EXEC] = inst_w[INST_EXEC];
        if (inst_w[INST_EXEC]) begin
            c_nxt_s = in_n;
        end else begin
            c_nxt_s = c_r;
        end
    end

    // State registers; reset wins over any load or execute in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_r          <= {w_bw{1'b0}};
            b_r          <= {w_bw{1'b0}};
            c_r          <= {psum_bw{1'b0}};
            inst_r       <= 2'b00;
            load_ready_r <= 1'b1;
        end else begin
            a_r          <= a_nxt_s;
            b_r          <= b_nxt_s;
            c_r          <= c_nxt_s;
            inst_r       <= inst_nxt_s;
            load_ready_r <= load_ready_nxt_s;
        end
    end

    assign out_e  = a_r;
    assign inst_e = inst_r;

    mac #(
        .a_bw    (bw),
        .w_bw    (w_bw),
        .psum_bw (psum_bw)
    ) u_mac (
        .a   (a_r[bw-1:0]),
        .b   (b_r),
        .c   (c_r),
        .out (out_s)
    );
endmodule

// File: tb/tb_mac_tile.sv
// Scoreboard bench for mac_tile: stimulus pushes expected outputs from an integer
// reference model; a negedge monitor pops and compares every cycle.
module tb_mac_tile;
    logic       clk;
    logic       reset;
    logic [3:0] in_w;
    logic [1:0] inst_w;
    logic [7:0] in_n;
    logic [3:0] out_e;
    logic [1:0] inst_e;
    logic [7:0] out_s;

    typedef struct {
        logic [3:0] out_e;
        logic [1:0] inst_e;
        logic [7:0] out_s;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, kept as plain integers.
    int   m_act;
    int   m_weight;
    int   m_psum;
    int   m_fwd_load;
    int   m_fwd_exec;
    bit   m_has_weight;

    mac_tile dut (
        .clk    (clk),
        .reset  (reset),
        .in_w   (in_w),
        .inst_w (inst_w),
        .in_n   (in_n),
        .out_e  (out_e),
        .inst_e (inst_e),
        .out_s  (out_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sext(input int v, input int bits);
        int m;
        m = v % (1 << bits);
        return (m >= (1 << (bits - 1))) ? m - (1 << bits) : m;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus: update the model, enqueue its prediction, then clock.
    task automatic drive(input bit rst_v, input logic [1:0] inst, input logic [3:0] w, input logic [7:0] n);
        exp_t e;
        reset  = rst_v;
        inst_w = inst;
        in_w   = w;
        in_n   = n;
        if (!rst_v) begin
            m_act = 0; m_weight = 0; m_psum = 0;
            m_fwd_load = 0; m_fwd_exec = 0; m_has_weight = 1'b0;
        end else begin
            if (inst != 2'b00) m_act = int'(w);
            m_fwd_load = 0;
            if (inst[0] == 1'b1) begin
                if (!m_has_weight) begin
                    m_weight = int'(w);
                    m_has_weight = 1'b1;
                end else begin
                    m_fwd_load = 1;
                end
            end
            m_fwd_exec = int'(inst[1]);
            if (inst[1] == 1'b1) m_psum = int'(n);
        end
        e.out_e  = 4'(m_act);
        e.inst_e = 2'(m_fwd_exec * 2 + m_fwd_load);
        e.out_s  = 8'((sext(m_act % 4, 2) * sext(m_weight, 4) + m_psum) & 255);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the tile presents a result for the previous stimulus.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("out_e",  8'(out_e),  8'(e.out_e));
            check("inst_e", 8'(inst_e), 8'(e.inst_e));
            check("out_s",  out_s,      e.out_s);
        end
    end

    initial begin
        bit drained;
        reset = 1'b0; inst_w = 2'b00; in_w = 4'h0; in_n = 8'h00;
        m_act = 0; m_weight = 0; m_psum = 0;
        m_fwd_load = 0; m_fwd_exec = 0; m_has_weight = 1'b0;

        // Reset with random inputs, then the directed load/execute sequence.
        repeat (2) drive(1'b0, 2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom));
        drive(1'b1, 2'b01, 4'b0010, 8'h00);
        drive(1'b1, 2'b01, 4'b0101, 8'h00);
        drive(1'b1, 2'b10, 4'b0001, 8'd3);
        drive(1'b1, 2'b10, 4'b0011, 8'd5);
        drive(1'b1, 2'b00, 4'b1111, 8'hAA);

        // Overflow wrap: weight 7, a=1, psum 127 wraps to -122.
        drive(1'b0, 2'b00, 4'h0, 8'h00);
        drive(1'b1, 2'b01, 4'b0111, 8'h00);
        drive(1'b1, 2'b10, 4'b0001, 8'd127);

        // Reset mid-execute, then a fresh load must be consumed locally.
        repeat (3) drive(1'b1, 2'b10, 4'($urandom), 8'($urandom));
        drive(1'b0, 2'b10, 4'($urandom), 8'($urandom));
        drive(1'b1, 2'b01, 4'b0110, 8'h00);
        drive(1'b1, 2'b11, 4'b1001, 8'd20);
        drive(1'b1, 2'b11, 4'b0010, 8'd40);

        // Combined load+execute as the tile's own first load.
        drive(1'b0, 2'b00, 4'h0, 8'h00);
        drive(1'b1, 2'b11, 4'b1011, 8'd9);
        drive(1'b1, 2'b10, 4'b0010, 8'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 24) != 0), 2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom));
        end
        drive(1'b1, 2'b00, 4'h0, 8'h00);

        drained = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_tile.md
# mac_tile

Registered processing element wrapping the combinational `mac` multiply-accumulate unit; the building block of the weight-stationary systolic array. Holds one stationary weight, forwards activations east and partial sums south with one-cycle registration, and daisy-chains load/execute instructions to the east neighbour. Instantiated in a row by the array row wrapper, directly above the output FIFO path.

## Interface
- `bw`, 2, activation width (matches `mac` `a_bw`)
- `w_bw`, 4, weight width and west/east data bus width (matches `mac` `w_bw`)
- `psum_bw`, 8, partial-sum width (matches `mac` `psum_bw`)

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low; sampled at rising edge of `clk`; 0 = reset
- `in_w`  in  w_bw  west data: weight during load, activation in bits [bw-1:0] during execute
- `inst_w`  in  2  west instruction: bit0 = load, bit1 = execute
- `in_n`  in  psum_bw  partial sum from north
- `out_e`  out  w_bw  registered west data forwarded east
- `inst_e`  out  2  registered instruction forwarded east
- `out_s`  out  psum_bw  partial sum to south

## Operation
- State: `a_q[w_bw]`, `b_q[w_bw]` (stationary weight), `c_q[psum_bw]`, `inst_q[2]`, `load_ready_q`.
- Reset (`reset`=0 at edge): `a_q`, `b_q`, `c_q`, `inst_q` = 0; `load_ready_q` = 1. Reset overrides all other activity, including mid-load or mid-execute.
- Data capture: if `inst_w` != 2'b00, `a_q` <= `in_w`; otherwise `a_q` holds.
- Weight load: if `inst_w[0]` and `load_ready_q`: `b_q` <= `in_w`, `load_ready_q` <= 0, `inst_q[0]` <= 0 (weight consumed locally, not forwarded as a load).
- Load pass-through: if `inst_w[0]` and not `load_ready_q`: `b_q` holds, `inst_q[0]` <= 1, so the east tile sees the load one cycle later with the same data on `out_e`.
- `inst_w[0]` = 0: `inst_q[0]` <= 0.
- Execute: `inst_q[1]` <= `inst_w[1]` always. If `inst_w[1]`, `c_q` <= `in_n`; else `c_q` holds.
- `load_ready_q` returns to 1 only via reset; one weight per tile per reset.
- Simultaneous `inst_w` = 2'b11: load and execute rules both apply in the same cycle; the executing MAC in the following cycle uses the newly loaded `b_q` if this was the tile's own load.
- Outputs: `out_e` = `a_q`, `inst_e` = `inst_q`, `out_s` = `mac(a = a_q[bw-1:0], b = b_q, c = c_q)`.
- Arithmetic (inside `mac`): `a`, `b` signed two's complement, sign-extended to `psum_bw`; result = a*b + c truncated to `psum_bw` bits (modular wrap, no saturation).

## Timing
- Latency: `in_w`/`inst_w` to `out_e`/`inst_e` = 1 cycle; `in_n` to `out_s` = 1 cycle (registered inputs, combinational `mac` after the registers).
- Weight load to first valid use: `b_q` valid the cycle after the load edge.
- N tiles in a row: the k-th load word (k = 0..N-1) lands in tile k, k cycles after entering tile 0.
- No backpressure; one instruction per cycle, every cycle.
- All outputs are 0 in the cycle after reset.

## Structure
- Shared package `mac_pkg`: localparams `INST_LOAD` = 0, `INST_EXEC` = 1, default widths `BW`, `W_BW`, `PSUM_BW`.
- One sub-module: existing `mac`, instantiated once with `a_bw` = `bw`, `w_bw`, `psum_bw` passed through.
- Row wrapper chains `out_e`/`inst_e` into the next tile's `in_w`/`inst_w`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random inputs -> `out_e`=0, `inst_e`=00, `out_s`=0, `load_ready_q`=1.
- First load: `inst_w`=01, `in_w`=4'b0010 -> next cycle `b_q`=2, `inst_e`=00, `out_e`=2, `load_ready_q`=0.
- Second load: `inst_w`=01, `in_w`=4'b0101 -> next cycle `inst_e`=01, `out_e`=5, `b_q` still 2.
- Execute with weight 2: `inst_w`=10, `in_w`=4'b0001, `in_n`=3 -> `out_s`=5, `inst_e`=10, `out_e`=1. Then `in_w`=4'b0011 (a=-1), `in_n`=5 -> `out_s`=3.
- Overflow wrap: after reset, load weight 7, execute a=1, `in_n`=127 -> `out_s`=8'b10000110 (-122).
- Reset mid-execute: `reset`=0 during a stream of `inst_w`=10 -> next cycle all outputs 0; load after reset is accepted locally (`inst_e`=00).
